// File: rtl/truth_table_pkg.sv
// Shared types for the truth-table sweeper: FSM state encoding and row-count helper.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int rows(input int nv);
    return 1 << nv;
  endfunction

endpackage

// File: rtl/truth_table_sequencer.sv
// Sweeps an evaluator through all 2^NV rows, SETTLE+1 cycles per row, capturing SoP/PoS truth tables.
// Flags rows where SoP and PoS disagree; start is only honoured in IDLE and never queued.
module truth_table_sequencer
  import truth_table_pkg::*;
#(
  parameter int NV     = 3,
  parameter int NF     = 2,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NF-1:0]          sop_in,
  input  logic [NF-1:0]          pos_in,
  output logic [NV-1:0]          vars,
  output logic                   busy,
  output logic                   done,
  output logic [NF*(1<<NV)-1:0]  table_sop,
  output logic [NF*(1<<NV)-1:0]  table_pos,
  output logic [NF-1:0]          mismatch,
  output logic [NF*(NV+1)-1:0]   mismatch_cnt
);

  localparam int ROWS = rows(NV);
  localparam int CW   = NV + 1;
  localparam int WW   = $clog2(SETTLE + 2);
  localparam logic [WW-1:0] WLAST = WW'(SETTLE > 0 ? SETTLE - 1 : 0);
  localparam state_t ROW_ENTRY = (SETTLE == 0) ? SAMPLE : APPLY;

  state_t              state, state_nxt;
  logic [CW-1:0]       row, row_nxt;
  logic [WW-1:0]       wait_cnt, wait_nxt;
  logic [NF*ROWS-1:0]  tsop_nxt, tpos_nxt;
  logic [NF-1:0]       mm_nxt;
  logic [NF*CW-1:0]    cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      row          <= '0;
      wait_cnt     <= '0;
      table_sop    <= '0;
      table_pos    <= '0;
      mismatch     <= '0;
      mismatch_cnt <= '0;
    end else begin
      state        <= state_nxt;
      row          <= row_nxt;
      wait_cnt     <= wait_nxt;
      table_sop    <= tsop_nxt;
      table_pos    <= tpos_nxt;
      mismatch     <= mm_nxt;
      mismatch_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    wait_nxt  = wait_cnt;
    tsop_nxt  = table_sop;
    tpos_nxt  = table_pos;
    mm_nxt    = mismatch;
    cnt_nxt   = mismatch_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          tsop_nxt  = '0;
          tpos_nxt  = '0;
          mm_nxt    = '0;
          cnt_nxt   = '0;
          row_nxt   = '0;
          wait_nxt  = '0;
          state_nxt = ROW_ENTRY;
        end
      end
      APPLY: begin
        wait_nxt = wait_cnt + 1'b1;
        if (wait_cnt == WLAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        for (int f = 0; f < NF; f++) begin
          for (int r = 0; r < ROWS; r++) begin
            if (row[NV-1:0] == NV'(r)) begin
              tsop_nxt[f*ROWS + r] = sop_in[f];
              tpos_nxt[f*ROWS + r] = pos_in[f];
            end
          end
          // Count saturates at ROWS so an all-rows disagreement still reads correctly.
          if (sop_in[f] != pos_in[f]) begin
            mm_nxt[f] = 1'b1;
            if (mismatch_cnt[f*CW +: CW] != CW'(ROWS))
              cnt_nxt[f*CW +: CW] = mismatch_cnt[f*CW +: CW] + 1'b1;
          end
        end
        if (row == CW'(ROWS - 1)) begin
          state_nxt = DONE;
        end else begin
          row_nxt   = row + 1'b1;
          wait_nxt  = '0;
          state_nxt = ROW_ENTRY;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vars = '0;
    busy = 1'b0;
    done = 1'b0;
    if (state == APPLY || state == SAMPLE) begin
      vars = row[NV-1:0];
      busy = 1'b1;
    end
    if (state == DONE) done = 1'b1;
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: two sequencers (SETTLE=1 and SETTLE=0) in front of a two-function evaluator.
module tb_truth_table_sequencer;

  typedef struct packed {
    logic [15:0] ts;
    logic [15:0] tp;
    logic [1:0]  mm;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0, start0 = 1'b0;
  int          fault = 0;
  int          n_cmp = 0, n_bad = 0;
  exp_t        sb1[$], sb0[$];

  logic [2:0]  vars1, vars0;
  logic        busy1, busy0, done1, done0;
  logic [15:0] ts1, tp1, ts0, tp0;
  logic [1:0]  mm1, mm0, sop_in1, pos_in1, sop_in0, pos_in0;
  logic [7:0]  cnt1, cnt0;
  logic        x, y, z, sopc, posc, sopd, posd;

  always #5 clk = ~clk;

  // c = z' + xy ; d = x' + y, each in SoP and PoS form
  function automatic logic [3:0] eval(input logic [2:0] v);
    logic a, b, c;
    {a, b, c} = v;
    return {(~a | b), (~a | b), ((a | ~c) & (b | ~c)), (~c | (a & b))};
  endfunction

  assign {x, y, z} = vars1;
  assign sopc = ~z | (x & y);
  assign posc = (x | ~z) & (y | ~z);
  assign sopd = ~x | y;
  assign posd = ~x | y;
  assign sop_in1 = (fault == 2) ? ~{sopd, sopc} : {sopd, sopc};
  assign pos_in1 = {((fault == 1) && (vars1 == 3'd4 || vars1 == 3'd5)) ? ~sopd : posd, posc};
  assign {pos_in0[1], sop_in0[1], pos_in0[0], sop_in0[0]} = eval(vars0);

  truth_table_sequencer #(.NV(3), .NF(2), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sop_in(sop_in1), .pos_in(pos_in1),
    .vars(vars1), .busy(busy1), .done(done1), .table_sop(ts1), .table_pos(tp1),
    .mismatch(mm1), .mismatch_cnt(cnt1));

  truth_table_sequencer #(.NV(3), .NF(2), .SETTLE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .sop_in(sop_in0), .pos_in(pos_in0),
    .vars(vars0), .busy(busy0), .done(done0), .table_sop(ts0), .table_pos(tp0),
    .mismatch(mm0), .mismatch_cnt(cnt0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_result(input string tag, input exp_t e, input logic [15:0] ts,
                            input logic [15:0] tp, input logic [1:0] mm, input logic [7:0] cnt);
    chk({tag, " table_sop"}, {16'h0, ts}, {16'h0, e.ts});
    chk({tag, " table_pos"}, {16'h0, tp}, {16'h0, e.tp});
    chk({tag, " mismatch"}, {30'h0, mm}, {30'h0, e.mm});
    chk({tag, " mismatch_cnt"}, {24'h0, cnt}, {24'h0, e.cnt});
  endtask

  always @(negedge clk) begin
    if (done1) begin
      if (sb1.size() == 0) chk("dut1 unexpected done", 32'd1, 32'd0);
      else chk_result("dut1", sb1.pop_front(), ts1, tp1, mm1, cnt1);
    end
    if (done0) begin
      if (sb0.size() == 0) chk("dut0 unexpected done", 32'd1, 32'd0);
      else chk_result("dut0", sb0.pop_front(), ts0, tp0, mm0, cnt0);
    end
  end

  // One sweep on the selected DUT; optional start re-pulses at cycles 3/10 and reset at cycle rst_at.
  task automatic sweep(input bit s0, input bit restarts, input int rst_at);
    int len, per;
    len = s0 ? 8 : 16;
    per = s0 ? 1 : 2;
    if (s0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      chk("busy in sweep", {31'h0, s0 ? busy0 : busy1}, 32'd1);
      chk("vars in sweep", {29'h0, s0 ? vars0 : vars1}, (i - 1) / per);
      chk("no early done", {31'h0, s0 ? done0 : done1}, 32'd0);
      if (restarts && (i == 3 || i == 10)) start1 = 1'b1;
      else start1 = 1'b0;
      if (i == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk("rst busy", {31'h0, busy1}, 32'd0);
        chk("rst vars", {29'h0, vars1}, 32'd0);
        chk("rst done", {31'h0, done1}, 32'd0);
        chk("rst tables", {ts1, tp1}, 32'd0);
        chk("rst mm/cnt", {22'h0, mm1, cnt1}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post-rst idle", {30'h0, busy1, done1}, 32'd0);
        return;
      end
    end
    @(negedge clk);
    chk("busy after sweep", {31'h0, s0 ? busy0 : busy1}, 32'd0);
    chk("done pulse", {31'h0, s0 ? done0 : done1}, 32'd1);
    @(negedge clk);
    chk("done one cycle", {31'h0, s0 ? done0 : done1}, 32'd0);
  endtask

  initial begin
    exp_t nominal;
    nominal = '{ts: 16'hCFD5, tp: 16'hCFD5, mm: 2'b00, cnt: 8'h00};
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy/done", {28'h0, busy1, done1, busy0, done0}, 32'd0);
    chk("reset vars", {26'h0, vars1, vars0}, 32'd0);
    chk("reset tables", {ts1, tp1}, 32'd0);
    chk("reset mm/cnt", {22'h0, mm1, cnt1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    sb1.push_back(nominal);
    sweep(1'b0, 1'b0, 0);

    fault = 1;
    sb1.push_back('{ts: 16'hCFD5, tp: 16'hFFD5, mm: 2'b10, cnt: 8'h20});
    sweep(1'b0, 1'b0, 0);
    fault = 0;

    sb0.push_back(nominal);
    sweep(1'b1, 1'b0, 0);

    sb1.push_back(nominal);
    sweep(1'b0, 1'b1, 0);

    sweep(1'b0, 1'b0, 9);
    sb1.push_back(nominal);
    sweep(1'b0, 1'b0, 0);

    fault = 2;
    sb1.push_back('{ts: 16'h302A, tp: 16'hCFD5, mm: 2'b11, cnt: 8'h88});
    sweep(1'b0, 1'b0, 0);
    fault = 0;

    repeat (4) @(negedge clk);
    chk("idle holds table_sop", {16'h0, ts1}, 32'h302A);
    chk("idle holds counts", {24'h0, cnt1}, 32'h88);
    chk("dut1 scoreboard drained", sb1.size(), 32'd0);
    chk("dut0 scoreboard drained", sb0.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
